eth_phy_link_mon: RTL

- MDIO management master in the 50 MHz Ethernet clock domain.
- Waits for the PHY to leave hardware reset (eth_rst_out from the reset generator), then holds a startup delay.
- Then periodically reads the PHY Basic Mode Status Register (reg 1) over MDIO, and publishes link status and the raw register value to the MAC/user logic.

---
 rtl/eth_phy_link_mon.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/eth_phy_link_mon.sv
// MDIO management master: waits for PHY reset release and a startup delay,
// then periodically reads one PHY register and publishes link status.
module eth_phy_link_mon #(
  parameter int unsigned MDC_DIV        = 10,
  parameter logic [4:0]  PHY_ADDR       = 5'd1,
  parameter logic [4:0]  REG_ADDR       = 5'd1,
  parameter int unsigned LINK_BIT       = 2,
  parameter int unsigned STARTUP_CYCLES = 50000,
  parameter int unsigned POLL_CYCLES    = 500000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        eth_rst_in,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i,
  output logic        link_up,
  output logic [15:0] status_reg,
  output logic        poll_done,
  output logic        mdio_err
);

  localparam int unsigned CNT_MAX = (STARTUP_CYCLES > POLL_CYCLES) ? STARTUP_CYCLES : POLL_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned DIV_W   = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
  localparam int unsigned BIT_W   = 6;

  localparam logic [BIT_W-1:0] RELEASE_BIT = BIT_W'(46);
  localparam logic [BIT_W-1:0] TA_BIT      = BIT_W'(47);
  localparam logic [BIT_W-1:0] DATA_BIT    = BIT_W'(48);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(63);

  // Driven frame bits, bit index 0 at the MSB; TA/data positions padded with 1.
  localparam logic [63:0] HDR = {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, REG_ADDR, 18'h3_FFFF};

  typedef enum logic [1:0] {
    WAIT_RST,
    STARTUP,
    FRAME,
    WAIT_POLL
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [DIV_W-1:0]  div, div_d;
  logic [BIT_W-1:0]  bit_idx, bit_d, nxt_bit;
  logic [15:0]       shift, shift_d;
  logic              ta_err, ta_err_d;
  logic              mdc_d, mdio_o_d, mdio_oe_d, link_d, poll_done_d, err_d;
  logic [15:0]       status_d;
  logic              div_wrap;

  // Value placed on MDIO for a given bit index
  function automatic logic frame_bit(input logic [BIT_W-1:0] idx);
    return HDR[BIT_W'(63) - idx];
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    div_d       = div;
    bit_d       = bit_idx;
    shift_d     = shift;
    ta_err_d    = ta_err;
    mdc_d       = mdc;
    mdio_o_d    = mdio_o;
    mdio_oe_d   = mdio_oe;
    link_d      = link_up;
    status_d    = status_reg;
    poll_done_d = 1'b0;
    err_d       = mdio_err;
    nxt_bit     = bit_idx + BIT_W'(1);
    div_wrap    = (div == DIV_W'(MDC_DIV - 1));

    if (eth_rst_in) begin
      // PHY back in reset: abandon everything except the last good results
      state_d   = WAIT_RST;
      cnt_d     = '0;
      div_d     = '0;
      bit_d     = '0;
      mdc_d     = 1'b0;
      mdio_o_d  = 1'b1;
      mdio_oe_d = 1'b0;
      link_d    = 1'b0;
    end else begin
      case (state)
        WAIT_RST: begin
          state_d = STARTUP;
          cnt_d   = '0;
          div_d   = '0;
          mdc_d   = 1'b0;
        end

        STARTUP, WAIT_POLL: begin
          div_d = '0;
          mdc_d = 1'b0;
          if (cnt == CNT_W'(((state == STARTUP) ? STARTUP_CYCLES : POLL_CYCLES) - 1)) begin
            state_d   = FRAME;
            cnt_d     = '0;
            bit_d     = '0;
            shift_d   = '0;
            ta_err_d  = 1'b0;
            mdio_o_d  = frame_bit('0);
            mdio_oe_d = 1'b1;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end

        FRAME: begin
          if (div_wrap) begin
            div_d = '0;
            mdc_d = ~mdc;
            if (!mdc) begin
              // Rising MDC: sample the PHY
              if (bit_idx == TA_BIT) ta_err_d = mdio_i;
              if (bit_idx >= DATA_BIT) shift_d = {shift[14:0], mdio_i};
            end else if (bit_idx == LAST_BIT) begin
              // Falling MDC after the last bit: publish the result
              state_d     = WAIT_POLL;
              cnt_d       = '0;
              bit_d       = '0;
              poll_done_d = 1'b1;
              mdio_o_d    = 1'b1;
              mdio_oe_d   = 1'b0;
              if (ta_err) begin
                err_d  = 1'b1;
                link_d = 1'b0;
              end else begin
                err_d    = 1'b0;
                status_d = shift;
                link_d   = shift[LINK_BIT];
              end
            end else begin
              // Falling MDC: launch the next bit
              bit_d     = nxt_bit;
              mdio_oe_d = (nxt_bit < RELEASE_BIT);
              mdio_o_d  = (nxt_bit < RELEASE_BIT) ? frame_bit(nxt_bit) : 1'b1;
            end
          end else begin
            div_d = div + DIV_W'(1);
          end
        end

        default: state_d = WAIT_RST;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= WAIT_RST;
      cnt        <= '0;
      div        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      ta_err     <= 1'b0;
      mdc        <= 1'b0;
      mdio_o     <= 1'b1;
      mdio_oe    <= 1'b0;
      link_up    <= 1'b0;
      status_reg <= '0;
      poll_done  <= 1'b0;
      mdio_err   <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      div        <= div_d;
      bit_idx    <= bit_d;
      shift      <= shift_d;
      ta_err     <= ta_err_d;
      mdc        <= mdc_d;
      mdio_o     <= mdio_o_d;
      mdio_oe    <= mdio_oe_d;
      link_up    <= link_d;
      status_reg <= status_d;
      poll_done  <= poll_done_d;
      mdio_err   <= err_d;
    end
  end

endmodule
